// File: rtl/ddr_fifo_pattern_gen_if.sv
// Write-side stream bus between the pattern generator and the DDR FIFO.
interface ddr_fifo_pattern_gen_if;
  logic [47:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/ddr_fifo_pattern_gen.sv
// Pattern generator for the DDR FIFO loopback path.
// Emits {cnt[15:0], cnt[31:0]} words with an incrementing counter. Bit 32 can be
// flipped on one word to exercise the checker.
module ddr_fifo_pattern_gen #(
  parameter logic [31:0] START_VALUE = 32'd0,
  parameter logic [31:0] NUM_PASSES  = 32'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          inject_err,
  ddr_fifo_pattern_gen_if.master        m_if,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   pass_cnt,
  output logic [31:0]                   stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [47:0] r_data;
  logic        r_valid;
  logic [31:0] r_pass;
  logic [31:0] r_stall;
  logic        r_inj;

  logic        w_xfer;
  logic        w_inj_pend;
  logic        w_wrap;
  logic        w_pass_hit;
  logic [31:0] w_cnt;

  // Mirror field is the low counter half; a corrupt word has bit 32 flipped.
  function automatic logic [47:0] make_word(input logic [31:0] c, input logic bad);
    return {c[15:1], c[0] ^ bad, c};
  endfunction

  assign w_cnt      = r_data[31:0];
  assign w_xfer     = r_valid & m_if.m_ready;
  // A pulse arriving in the same cycle as a word load already marks that word.
  assign w_inj_pend = r_inj | inject_err;
  assign w_wrap     = w_xfer && (w_cnt == 32'hFFFF_FFFF);
  assign w_pass_hit = w_wrap && (NUM_PASSES != 32'd0) && ((r_pass + 32'd1) == NUM_PASSES);

  assign m_if.m_data  = r_data;
  assign m_if.m_valid = r_valid;
  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign pass_cnt     = r_pass;
  assign stall_cnt    = r_stall;

  // Run-control FSM, word generation and the pass/stall statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pass  <= '0;
      r_stall <= '0;
      r_inj   <= 1'b0;
    end else begin
      // Defaults: latch a pending injection, count stalls and counter wraps.
      r_inj <= w_inj_pend;
      if (r_valid && !m_if.m_ready && (r_stall != 32'hFFFF_FFFF))
        r_stall <= r_stall + 32'd1;
      if (w_wrap)
        r_pass <= r_pass + 32'd1;

      case (r_state)
        S_IDLE, S_DONE: begin
          // stop beats start here, so a simultaneous pair leaves the state alone.
          if (start && !stop) begin
            r_state <= S_RUN;
            r_data  <= make_word(START_VALUE, w_inj_pend);
            r_inj   <= 1'b0;
            r_valid <= 1'b1;
            r_pass  <= '0;
            r_stall <= '0;
          end
        end
        S_RUN: begin
          if (w_pass_hit) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
          end else if (stop) begin
            if (w_xfer) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (w_xfer) begin
            r_data <= make_word(w_cnt + 32'd1, w_inj_pend);
            r_inj  <= 1'b0;
          end
        end
        default: begin
          // DRAIN: hold the last word until it is taken, then stop issuing.
          if (w_xfer) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_fifo_pattern_gen.sv
module tb_ddr_fifo_pattern_gen;

  typedef struct {
    bit          u;                 // 0: default instance, 1: wrap-limited instance
    bit          st, sp, inj, rdy;  // inputs held for one cycle
    bit          ev, cd;            // expected valid, compare data
    logic [47:0] ed;
    bit          eb, edn;
    logic [31:0] ep, es;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st0 = 0, sp0 = 0, ij0 = 0;
  logic st1 = 0, sp1 = 0, ij1 = 0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] pass0, stall0, pass1, stall1;

  int nvec = 0;
  int nerr = 0;
  vec_t tv[$];

  ddr_fifo_pattern_gen_if if0 ();
  ddr_fifo_pattern_gen_if if1 ();

  ddr_fifo_pattern_gen #(.START_VALUE(32'd0), .NUM_PASSES(32'd0)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .stop(sp0), .inject_err(ij0),
    .m_if(if0.master), .busy(busy0), .done(done0), .pass_cnt(pass0), .stall_cnt(stall0));

  ddr_fifo_pattern_gen #(.START_VALUE(32'hFFFF_FFFD), .NUM_PASSES(32'd1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .stop(sp1), .inject_err(ij1),
    .m_if(if1.master), .busy(busy1), .done(done1), .pass_cnt(pass1), .stall_cnt(stall1));

  always #5 clk = ~clk;

  function automatic logic [47:0] W(input logic [31:0] c, input bit bad = 0);
    logic [15:0] m;
    m = c[15:0];
    if (bad) m[0] = ~m[0];
    return {m, c};
  endfunction

  function automatic vec_t V(input bit u, input bit st, input bit sp, input bit inj, input bit rdy,
                             input bit ev, input bit cd, input logic [47:0] ed, input bit eb,
                             input bit edn, input logic [31:0] ep, input logic [31:0] es);
    vec_t v;
    v.u = u; v.st = st; v.sp = sp; v.inj = inj; v.rdy = rdy;
    v.ev = ev; v.cd = cd; v.ed = ed; v.eb = eb; v.edn = edn; v.ep = ep; v.es = es;
    return v;
  endfunction

  task automatic compare(input string nm, input bit u, input bit ev, input bit cd,
                         input logic [47:0] ed, input bit eb, input bit edn,
                         input logic [31:0] ep, input logic [31:0] es);
    logic [114:0] a, e;
    if (u) a = {if1.m_valid, busy1, done1, pass1, stall1, if1.m_data};
    else   a = {if0.m_valid, busy0, done0, pass0, stall0, if0.m_data};
    e = {ev, eb, edn, ep, es, ed};
    if (!cd) a[47:0] = e[47:0];
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s {valid,busy,done,pass,stall,data} got=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    st0 = !v.u && v.st; sp0 = !v.u && v.sp; ij0 = !v.u && v.inj; if0.m_ready = !v.u && v.rdy;
    st1 =  v.u && v.st; sp1 =  v.u && v.sp; ij1 =  v.u && v.inj; if1.m_ready =  v.u && v.rdy;
    @(posedge clk);
    #1;
    compare($sformatf("vec%0d", idx), v.u, v.ev, v.cd, v.ed, v.eb, v.edn, v.ep, v.es);
  endtask

  initial begin
    if0.m_ready = 1'b0;
    if1.m_ready = 1'b0;

    // Instance 0: START_VALUE=0, unlimited passes.
    tv.push_back(V(0, 1,0,0,1, 1,1,W(0),1,0,0,0));
    for (int k = 1; k <= 9; k++) tv.push_back(V(0, 0,0,0,1, 1,1,W(k),1,0,0,0));
    tv.push_back(V(0, 0,0,0,1, 1,1,W(10),1,0,0,0));
    tv.push_back(V(0, 0,0,0,0, 1,1,W(10),1,0,0,1));
    tv.push_back(V(0, 0,0,0,0, 1,1,W(10),1,0,0,2));
    tv.push_back(V(0, 0,0,0,1, 1,1,W(11),1,0,0,2));
    tv.push_back(V(0, 0,0,1,1, 1,1,W(12,1),1,0,0,2));
    tv.push_back(V(0, 0,0,0,1, 1,1,W(13),1,0,0,2));
    tv.push_back(V(0, 0,0,1,0, 1,1,W(13),1,0,0,3));
    tv.push_back(V(0, 0,0,0,0, 1,1,W(13),1,0,0,4));
    tv.push_back(V(0, 0,0,0,1, 1,1,W(14,1),1,0,0,4));
    tv.push_back(V(0, 0,0,1,0, 1,1,W(14,1),1,0,0,5));
    tv.push_back(V(0, 0,0,1,0, 1,1,W(14,1),1,0,0,6));
    tv.push_back(V(0, 0,0,0,1, 1,1,W(15,1),1,0,0,6));
    tv.push_back(V(0, 0,0,0,1, 1,1,W(16),1,0,0,6));
    tv.push_back(V(0, 1,0,0,1, 1,1,W(17),1,0,0,6));   // start ignored in RUN
    tv.push_back(V(0, 0,1,0,0, 1,1,W(17),1,0,0,7));   // stop with word pending -> DRAIN
    tv.push_back(V(0, 0,0,0,0, 1,1,W(17),1,0,0,8));
    tv.push_back(V(0, 0,1,0,0, 1,1,W(17),1,0,0,9));   // stop ignored in DRAIN
    tv.push_back(V(0, 0,0,0,1, 0,0,48'h0,0,0,0,9));   // drained -> IDLE
    tv.push_back(V(0, 0,0,0,1, 0,0,48'h0,0,0,0,9));   // no next word
    tv.push_back(V(0, 1,1,0,0, 0,0,48'h0,0,0,0,9));   // stop wins over start
    tv.push_back(V(0, 1,0,0,0, 1,1,W(0),1,0,0,0));
    tv.push_back(V(0, 0,1,0,1, 0,0,48'h0,0,0,0,0));   // stop with transfer -> IDLE
    tv.push_back(V(0, 0,0,0,1, 0,0,48'h0,0,0,0,0));
    tv.push_back(V(0, 0,0,1,0, 0,0,48'h0,0,0,0,0));   // inject while idle stays pending
    tv.push_back(V(0, 1,0,0,0, 1,1,W(0,1),1,0,0,0));  // start loads the corrupt word
    tv.push_back(V(0, 0,0,0,1, 1,1,W(1),1,0,0,0));
    tv.push_back(V(0, 0,0,0,0, 1,1,W(1),1,0,0,1));
    // Instance 1: START_VALUE=FFFFFFFD, one pass.
    tv.push_back(V(1, 1,0,0,0, 1,1,W(32'hFFFF_FFFD),1,0,0,0));
    tv.push_back(V(1, 0,0,0,1, 1,1,W(32'hFFFF_FFFE),1,0,0,0));
    tv.push_back(V(1, 0,0,0,0, 1,1,W(32'hFFFF_FFFE),1,0,0,1));
    tv.push_back(V(1, 0,0,0,1, 1,1,W(32'hFFFF_FFFF),1,0,0,1));
    tv.push_back(V(1, 0,1,0,1, 0,0,48'h0,0,1,1,1));   // pass limit beats stop
    tv.push_back(V(1, 0,1,0,1, 0,0,48'h0,0,1,1,1));   // stop ignored in DONE
    tv.push_back(V(1, 1,1,0,0, 0,0,48'h0,0,1,1,1));   // stop wins over start in DONE
    tv.push_back(V(1, 1,0,0,0, 1,1,W(32'hFFFF_FFFD),1,0,0,0));
    tv.push_back(V(1, 0,0,0,1, 1,1,W(32'hFFFF_FFFE),1,0,0,0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    compare("reset0", 0, 0, 1, 48'h0, 0, 0, 0, 0);
    compare("reset1", 1, 0, 1, 48'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[i]) apply(tv[i], i);

    // Asynchronous reset in the middle of a run, away from any clock edge.
    @(negedge clk);
    st0 = 0; sp0 = 0; ij0 = 0; if0.m_ready = 1'b1;
    st1 = 0; sp1 = 0; ij1 = 0; if1.m_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    compare("async_rst0", 0, 0, 1, 48'h0, 0, 0, 0, 0);
    compare("async_rst1", 1, 0, 1, 48'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    apply(V(0, 1,0,0,1, 1,1,W(0),1,0,0,0), 100);
    apply(V(0, 0,0,0,1, 1,1,W(1),1,0,0,0), 101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ddr_fifo_pattern_gen.md
# ddr_fifo_pattern_gen

Source stage of the DDR FIFO loopback test path: generates the 48-bit self-checking word stream written into the DDR FIFO, which the data checker consumes on the read side. Each word carries a 32-bit incrementing counter in [31:0] and a copy of counter[15:0] in [47:32]. Output uses a valid/ready handshake, run/stop control, a pass (wrap) counter and single-shot error injection for exercising the checker.

## Interface
Parameters:
- START_VALUE, 32'd0: counter value of the first word after each start.
- NUM_PASSES, 32'd0: number of counter wraps before entering DONE; 0 means run until stop.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- stop  in  1  one-cycle pulse; ends a run from RUN.
- inject_err  in  1  one-cycle pulse; corrupts the mirror field of one upcoming word.
- m_data  out  48  word to the FIFO write port.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  FIFO accepts the word this cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass_cnt  out  32  number of accepted words with [31:0]==32'hFFFFFFFF since the last start.
- stall_cnt  out  32  cycles with m_valid=1 and m_ready=0 since the last start; saturates at 32'hFFFFFFFF.

## Operation
- Reset (rst=0): state IDLE; m_data=0, m_valid=0, busy=0, done=0, pass_cnt=0, stall_cnt=0, inject pending flag=0.
- Word format: m_data[31:0]=cnt; m_data[47:32]=cnt[15:0], with bit 32 inverted when the word is marked corrupt.
- Handshake: a transfer occurs when m_valid && m_ready. While m_valid=1 and m_ready=0, m_data is held stable and m_valid does not drop.
- States:
  - IDLE: m_valid=0. On start, load cnt=START_VALUE, clear pass_cnt and stall_cnt, and go to RUN.
  - RUN: m_valid=1. On each transfer, cnt increments by 1, wrapping modulo 2^32. An accepted word with cnt==32'hFFFFFFFF increments pass_cnt.
    - If NUM_PASSES!=0 and that increment makes pass_cnt==NUM_PASSES, go to DONE.
    - On stop: with no pending unaccepted word (transfer in the same cycle), go to IDLE. Otherwise go to DRAIN.
  - DRAIN: m_valid stays 1 with the same data. On the transfer, go to IDLE. No new word is issued.
  - DONE: m_valid=0 and done=1. On start, reload exactly as from IDLE.
- start is ignored in RUN and DRAIN. stop is ignored in IDLE, DONE and DRAIN. start and stop in the same cycle in IDLE or DONE: stop wins and the state is unchanged.
- Pass-limit and stop in the same cycle: DONE wins.
- Error injection:
  - inject_err sets the pending flag. The next word loaded into m_data is marked corrupt and the flag clears. A word is loaded either by a transfer in RUN or by start.
  - The counter sequence in [31:0] is unaffected.
  - inject_err while the flag is already set has no additional effect.
  - The flag is cleared by reset only; it survives stop and start.

## Timing
- start sampled at edge N: at N+1, m_valid=1, m_data[31:0]=START_VALUE, busy=1.
- With m_ready held high, one word per cycle with consecutive counter values and no valid gaps, as the downstream checker requires.
- A transfer at edge N presents the next word at N+1, with zero-bubble throughput.
- stall_cnt increments at the edge following each stalled cycle.
- Transition to DONE or IDLE: m_valid=0 from the next cycle. done asserts in the same cycle busy deasserts.
- Reset mid-run forces all outputs to their reset values immediately (asynchronous). Release is synchronized to clk by the system reset bridge.

## Test plan
- Reset, then start with START_VALUE=0 and m_ready=1 for 10 cycles -> m_data[31:0]=0..9 on consecutive cycles, [47:32]==[15:0], stall_cnt=0.
- m_ready toggles 1,0,0,1 -> the word presented during the low cycles is held unchanged, the next value appears after the accepting edge, and stall_cnt=2.
- START_VALUE=32'hFFFFFFFD, NUM_PASSES=1 -> words FFFFFFFD, FFFFFFFE, FFFFFFFF accepted, then pass_cnt=1, done=1, m_valid=0.
- stop while m_ready=0 with word 0x5 pending -> DRAIN holds 0x5. When m_ready rises, 0x5 transfers, then IDLE with m_valid=0 and no word 0x6.
- inject_err while word 0x20 is presented -> word 0x21 has [47:32]=16'h0020 and the following word 0x22 is correct.
- Assert rst mid-run with m_valid=1 -> m_valid, m_data and the counters are 0 immediately. start after release -> the run restarts from START_VALUE.
